// File: rtl/stream_serializer_pkg.sv
// Shared helpers for stream_serializer: counter/length widths and parameter sanity check.
package stream_serializer_pkg;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned len_width(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   function automatic bit check_param_pos(input int unsigned v);
      return v >= 1;
   endfunction

endpackage

// File: rtl/stream_serializer.sv
// Wide-word to narrow-beat valid-ready serializer, LSB beat first, zero-bubble reload.
// Optional STREAM_SERIALIZER_LEN_EN adds i_len to emit a shortened word.
module stream_serializer
   import stream_serializer_pkg::*;
#(
   parameter int unsigned W = 8,
   parameter int unsigned N = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      clk_en,
   input  logic                      i_valid,
   output logic                      i_ready,
   input  logic [N*W-1:0]            i,
`ifdef STREAM_SERIALIZER_LEN_EN
   input  logic [len_width(N)-1:0]   i_len,
`endif
   output logic                      o_valid,
   input  logic                      o_ready,
   output logic [W-1:0]              o,
   output logic                      o_last
);

   localparam int unsigned CW = cnt_width(N);
   localparam logic [CW-1:0] LastIdx = CW'(N - 1);

   if (!check_param_pos(W) || !check_param_pos(N)) begin : g_bad_param
      $error("stream_serializer: W and N must be >= 1");
   end

   logic [N*W-1:0] r_buf, w_buf_d;
   logic [CW-1:0]  r_cnt, w_cnt_d;
   logic           r_valid, w_valid_d;
   logic [CW-1:0]  r_last_idx, w_last_idx_d;
   logic [CW-1:0]  w_last_idx_in;
   logic           w_last;
   logic           w_load;

`ifdef STREAM_SERIALIZER_LEN_EN
   // Zero or oversize lengths fall back to a full word.
   always_comb begin
      w_last_idx_in = LastIdx;
      if (i_len != '0 && 32'(i_len) <= N) begin
         w_last_idx_in = CW'(32'(i_len) - 1);
      end
   end
`else
   assign w_last_idx_in = LastIdx;
`endif

   assign w_last  = r_valid && (r_cnt == r_last_idx);
   assign i_ready = !r_valid || (o_ready && w_last);
   assign w_load  = i_valid && i_ready;

   assign o_valid = r_valid;
   assign o_last  = w_last;
   assign o       = r_buf[32'(r_cnt) * W +: W];

   always_comb begin
      w_buf_d      = r_buf;
      w_cnt_d      = r_cnt;
      w_valid_d    = r_valid;
      w_last_idx_d = r_last_idx;
      if (w_load) begin
         w_buf_d      = i;
         w_cnt_d      = '0;
         w_valid_d    = 1'b1;
         w_last_idx_d = w_last_idx_in;
      end else if (r_valid && o_ready) begin
         if (w_last) begin
            w_valid_d = 1'b0;
            w_cnt_d   = '0;
         end else begin
            w_cnt_d = r_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_buf      <= '0;
         r_cnt      <= '0;
         r_valid    <= 1'b0;
         r_last_idx <= LastIdx;
      end else if (clk_en) begin
         r_buf      <= w_buf_d;
         r_cnt      <= w_cnt_d;
         r_valid    <= w_valid_d;
         r_last_idx <= w_last_idx_d;
      end
   end

endmodule

// File: tb/tb_stream_serializer.sv
// Scoreboard bench for stream_serializer (W=8, N=4) plus an N=1 instance.
module tb_stream_serializer;
   import stream_serializer_pkg::*;

   localparam int unsigned W = 8;
   localparam int unsigned N = 4;

   typedef struct {
      logic [W-1:0] data;
      logic         last;
   } beat_t;

   logic           clk = 1'b0;
   logic           rst_n, clk_en, i_valid, o_ready;
   logic           i_ready, o_valid, o_last;
   logic [N*W-1:0] i;
   logic [W-1:0]   o;
   logic [len_width(N)-1:0] i_len;
   logic           i_ready1, o_valid1, o_last1;
   logic [W-1:0]   o1;

   int n_tests = 0;
   int n_fail  = 0;
   int n_pops  = 0;

   beat_t          sb[$];
   logic [N*W-1:0] tx_q[$];
   logic [len_width(N)-1:0] len_q[$];
   logic           rdy_q[$];
   logic           rdy_def = 1'b1;
   logic           m1_valid = 1'b0;
   logic [W-1:0]   m1_data = '0;

   always #5 clk = ~clk;

   stream_serializer #(.W(W), .N(N)) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .clk_en  (clk_en),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .i       (i),
`ifdef STREAM_SERIALIZER_LEN_EN
      .i_len   (i_len),
`endif
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o       (o),
      .o_last  (o_last)
   );

   stream_serializer #(.W(W), .N(1)) u_dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .clk_en  (clk_en),
      .i_valid (i_valid),
      .i_ready (i_ready1),
      .i       (i[W-1:0]),
`ifdef STREAM_SERIALIZER_LEN_EN
      .i_len   (1'b0),
`endif
      .o_valid (o_valid1),
      .o_ready (o_ready),
      .o       (o1),
      .o_last  (o_last1)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push_word(input logic [N*W-1:0] w, input logic [len_width(N)-1:0] len);
      int unsigned nb;
      beat_t b;
      nb = N;
`ifdef STREAM_SERIALIZER_LEN_EN
      if (len != '0 && 32'(len) <= N) nb = len;
`endif
      for (int k = 0; k < int'(nb); k++) begin
         b.data = W'(w >> (k * W));
         b.last = (k == int'(nb) - 1);
         sb.push_back(b);
      end
   endtask

   // One cycle: drive after the edge, compare against the model at the falling edge.
   task automatic step();
      i_valid = (tx_q.size() != 0);
      i       = (tx_q.size() != 0) ? tx_q[0] : '0;
      i_len   = (len_q.size() != 0) ? len_q[0] : '0;
      o_ready = (rdy_q.size() != 0) ? rdy_q.pop_front() : rdy_def;
      @(negedge clk);
      if (!rst_n) begin
         sb.delete();
         m1_valid = 1'b0;
      end else begin
         check_eq("o_valid", 32'(o_valid), 32'(sb.size() != 0));
         check_eq("i_ready", 32'(i_ready),
                  32'(sb.size() == 0 || (o_ready && sb[0].last)));
         if (o_valid && sb.size() != 0) begin
            check_eq("o", 32'(o), 32'(sb[0].data));
            check_eq("o_last", 32'(o_last), 32'(sb[0].last));
         end
         check_eq("n1_o_last", 32'(o_last1), 32'(o_valid1));
         check_eq("n1_o_valid", 32'(o_valid1), 32'(m1_valid));
         if (m1_valid) check_eq("n1_o", 32'(o1), 32'(m1_data));
         if (clk_en) begin
            if (o_valid && o_ready && sb.size() != 0) begin
               void'(sb.pop_front());
               n_pops++;
            end
            if (i_valid && i_ready) begin
               push_word(tx_q[0], i_len);
               void'(tx_q.pop_front());
               if (len_q.size() != 0) void'(len_q.pop_front());
            end
            if (i_valid && (!m1_valid || o_ready)) begin
               m1_valid = 1'b1;
               m1_data  = i[W-1:0];
            end else if (o_ready) begin
               m1_valid = 1'b0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int max_cycles);
      for (int c = 0; c < max_cycles && (sb.size() != 0 || tx_q.size() != 0); c++) step();
      check_eq("drain_sb", 32'(sb.size()), 32'd0);
      check_eq("drain_tx", 32'(tx_q.size()), 32'd0);
      step();
   endtask

   initial begin
      rst_n = 1'b0; clk_en = 1'b1; i_valid = 1'b0; o_ready = 1'b1; i = '0; i_len = '0;
      @(posedge clk); #1;

      // 1: reset with i_valid asserted must not load
      tx_q.push_back(32'h44332211);
      step(); step();
      tx_q.delete();
      rst_n = 1'b1;
      step();
      check_eq("rst_o_valid", 32'(o_valid), 32'd0);
      check_eq("rst_o", 32'(o), 32'd0);
      check_eq("rst_o_last", 32'(o_last), 32'd0);
      check_eq("rst_i_ready", 32'(i_ready), 32'd1);

      // 2: full-rate single word
      tx_q.push_back(32'h44332211);
      n_pops = 0;
      drain(20);
      check_eq("t2_beats", 32'(n_pops), 32'd4);

      // 3: stalls on the output side
      tx_q.push_back(32'h44332211);
      rdy_q = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      drain(30);

      // 4: back-to-back words, no bubble
      tx_q.push_back(32'h44332211);
      tx_q.push_back(32'h88776655);
      step();
      n_pops = 0;
      for (int c = 0; c < 8; c++) step();
      check_eq("t4_beats_in_8", 32'(n_pops), 32'd8);
      drain(10);

      // 5: reset mid-word, then a clean restart at beat 0
      tx_q.push_back(32'h44332211);
      step(); step(); step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      check_eq("t5_o_valid", 32'(o_valid), 32'd0);
      tx_q.push_back(32'hDDCCBBAA);
      drain(20);

      // clk_en low freezes state mid-word
      tx_q.push_back(32'h0D0C0B0A);
      step(); step();
      clk_en = 1'b0;
      step(); step();
      clk_en = 1'b1;
      drain(20);

`ifdef STREAM_SERIALIZER_LEN_EN
      // 6: shortened and zero-length (full) words
      tx_q.push_back(32'h44332211); len_q.push_back(3'd2);
      tx_q.push_back(32'h88776655); len_q.push_back(3'd0);
      tx_q.push_back(32'hCCBBAA99); len_q.push_back(3'd7);
      n_pops = 0;
      drain(30);
      check_eq("t6_beats", 32'(n_pops), 32'd10);
`endif

      // random traffic
      for (int k = 0; k < 6; k++) tx_q.push_back($urandom);
      for (int k = 0; k < 60; k++) rdy_q.push_back(1'($urandom_range(0, 1)));
      for (int c = 0; c < 60; c++) step();
      rdy_def = 1'b1;
      drain(40);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
